rca_op_sequencer: RTL and testbench

//  Operand sequencer and result capture stage directly upstream and downstream of the
//  16-bit ripple carry adder, whose carry chain is built from 4-bit slices with a

---
 rtl/rca_op_sequencer.sv | 139 +++++++++++++
 tb/tb_rca_op_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_op_sequencer.sv
// Operand sequencer and result capture around a registered-carry ripple adder.
// Holds operands stable while carries settle, then captures and checks the sum.
module rca_op_sequencer #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             Rs,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  output logic             add_clr,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             err_flag
);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    SETTLE,
    DONE
  } state_t;

  localparam int MSB = WIDTH - 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     ref_sum;
  logic               mismatch;
  logic               ovf_now;

  always_ff @(posedge clk) begin
    if (Rs) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Behavioural reference, one bit wider so the carry-out is compared too
  always_comb begin
    ref_sum  = {1'b0, a_q} + {1'b0, b_q}
             + {{WIDTH{1'b0}}, cin_q};
    mismatch = ({add_carry, add_sum} != ref_sum);
    ovf_now  = (a_q[MSB] == b_q[MSB])
             & (add_sum[MSB] != a_q[MSB]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          state_d = CLR;
        end
      end
      CLR: begin
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          sum_d   = add_sum;
          carry_d = add_carry;
          ovf_d   = ovf_now;
          err_d   = err_q | mismatch;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) & ~Rs;
    add_clr   = (state_q == CLR) | Rs;
    out_valid = (state_q == DONE) & ~Rs;
    add_a     = a_q;
    add_b     = b_q;
    add_cin   = cin_q;
    out_sum   = sum_q;
    out_carry = carry_q;
    out_ovf   = ovf_q;
    err_flag  = err_q;
  end

endmodule

// File: tb/tb_rca_op_sequencer.sv
// Directed bench for rca_op_sequencer with a registered-carry adder model
// and a result scoreboard.
module tb_rca_op_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         Rs;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic         add_clr;
  logic [W-1:0] add_sum;
  logic         add_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_ovf;
  logic         err_flag;

  always #5 clk = ~clk;

  rca_op_sequencer #(
    .WIDTH  (W),
    .LATENCY(16),
    .CNT_W  (5)
  ) dut (
    .clk      (clk),
    .Rs       (Rs),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_clr  (add_clr),
    .add_sum  (add_sum),
    .add_carry(add_carry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_carry(out_carry),
    .out_ovf  (out_ovf),
    .err_flag (err_flag)
  );

  // Adder model: one flop per internal carry, bit k valid k edges after clear
  logic [W-1:1] cq;
  logic [W-1:0] cv;
  logic         fault;

  always_comb begin
    cv = {cq, add_cin};
  end

  always_comb begin
    add_sum   = add_a ^ add_b ^ cv ^ {{(W-1){1'b0}}, fault};
    add_carry = (add_a[W-1] & add_b[W-1])
              | ((add_a[W-1] ^ add_b[W-1]) & cv[W-1]);
  end

  always_ff @(posedge clk) begin
    if (add_clr) cq <= '0;
    else
      for (int i = 1; i < W; i++)
        cq[i] <= (add_a[i-1] & add_b[i-1])
               | ((add_a[i-1] ^ add_b[i-1]) & cv[i-1]);
  end

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         err;
  } exp_t;

  exp_t sb[$];
  logic err_exp;
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic accept(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c);
    logic [W:0] full;
    exp_t       e;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    chk({tag, "_rdy"}, in_ready, 1);
    full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum   = full[W-1:0] ^ {{(W-1){1'b0}}, fault};
    e.carry = full[W];
    e.ovf   = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    err_exp = err_exp | fault;
    e.err   = err_exp;
    sb.push_back(e);
    cyc(1);
    in_valid = 1'b0;
  endtask

  // Offers junk operands while busy; they must be ignored
  task automatic wait_result(input string tag, input logic [W-1:0] a);
    int n;
    n        = 1;
    in_valid = 1'b1;
    in_a     = ~a;
    in_b     = 16'h5a5a;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, n, 18);
    chk({tag, "_adda"}, add_a, a);
  endtask

  task automatic take_result(input string tag, input int hold,
                             input logic offer, input logic [W-1:0] na);
    logic         stable;
    logic [W-1:0] s0;
    logic [W-1:0] a0;
    exp_t         e;
    stable = 1'b1;
    s0     = out_sum;
    a0     = add_a;
    repeat (hold) begin
      cyc(1);
      if (!out_valid || out_sum !== s0 || in_ready) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold"}, stable, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, out_sum, e.sum);
      chk({tag, "_carry"}, out_carry, e.carry);
      chk({tag, "_ovf"}, out_ovf, e.ovf);
      chk({tag, "_err"}, err_flag, e.err);
    end
    out_ready = 1'b1;
    if (offer) begin
      in_valid = 1'b1;
      in_a     = na;
      in_b     = 16'h0004;
      in_cin   = 1'b0;
    end
    cyc(1);
    out_ready = 1'b0;
    chk({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
    if (offer) chk({tag, "_noacc"}, add_a, a0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    Rs        = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    fault     = 1'b0;
    err_exp   = 1'b0;
    @(negedge clk);
    cyc(3);
    chk("rst_rdy", in_ready, 0);
    chk("rst_clr", add_clr, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_outs", {out_sum, out_carry, out_ovf, err_flag}, 0);
    chk("rst_adds", {add_a, add_b, add_cin}, 0);
    Rs = 1'b0;
    cyc(1);
    chk("rel_rdy", in_ready, 1);
    chk("rel_clr", add_clr, 0);

    accept("op1", 16'h1234, 16'h4321, 1'b0);
    wait_result("op1", 16'h1234);
    take_result("op1", 0, 1'b0, '0);

    accept("op2", 16'hFFFF, 16'h0000, 1'b1);
    wait_result("op2", 16'hFFFF);
    take_result("op2", 0, 1'b0, '0);

    accept("op3", 16'h7FFF, 16'h0001, 1'b0);
    wait_result("op3", 16'h7FFF);
    take_result("op3", 10, 1'b0, '0);

    accept("op4", 16'h8000, 16'h8000, 1'b0);
    wait_result("op4", 16'h8000);
    take_result("op4", 0, 1'b1, 16'h0003);

    accept("op5", 16'h0003, 16'h0004, 1'b0);
    wait_result("op5", 16'h0003);
    take_result("op5", 0, 1'b0, '0);

    begin : abort_blk
      logic seen;
      seen = 1'b0;
      accept("abt", 16'h00FF, 16'h0001, 1'b0);
      void'(sb.pop_back());
      cyc(5);
      Rs = 1'b1;
      cyc(1);
      chk("abt_clr", add_clr, 1);
      chk("abt_rdy", in_ready, 0);
      Rs = 1'b0;
      #1;
      chk("abt_rel_rdy", in_ready, 1);
      repeat (25) begin
        cyc(1);
        if (out_valid) seen = 1'b1;
      end
      chk("abt_novld", seen, 0);
    end

    fault = 1'b1;
    accept("flt", 16'h0001, 16'h0001, 1'b0);
    wait_result("flt", 16'h0001);
    take_result("flt", 0, 1'b0, '0);
    fault = 1'b0;

    accept("sticky", 16'h0010, 16'h0020, 1'b0);
    wait_result("sticky", 16'h0010);
    take_result("sticky", 0, 1'b0, '0);

    Rs = 1'b1;
    cyc(1);
    Rs      = 1'b0;
    err_exp = 1'b0;
    cyc(1);
    chk("err_clr", err_flag, err_exp);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
